// File: rtl/pulse_stretcher_pkg.sv
// Shared types and constants for the pulse stretcher block.
// Optional retrigger behaviour is selected in pulse_stretcher.sv via STRETCH_RETRIGGER_EN.
package pulse_pkg;

  localparam int DEFAULT_LEN_W   = 8;
  localparam int DEFAULT_HOLDOFF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STRETCH = 2'd1,
    HOLD    = 2'd2
  } stretch_state_t;

  // done and ovr are single-cycle, active-high pulses
  typedef logic pulse_t;
  localparam pulse_t PULSE_ON  = 1'b1;
  localparam pulse_t PULSE_OFF = 1'b0;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int count_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/length inputs and stretched/status outputs of the pulse stretcher.
// Optional retrigger behaviour is selected in pulse_stretcher.sv via STRETCH_RETRIGGER_EN.
interface pulse_stretcher_if
  import pulse_pkg::*;
#(
  parameter int LEN_W = DEFAULT_LEN_W
) ();

  logic             trig;
  logic [LEN_W-1:0] len;
  logic             dout;
  pulse_t           done;
  pulse_t           ovr;

  modport master (output trig, output len, input dout, input done, input ovr);
  modport slave  (input trig, input len, output dout, output done, output ovr);

endinterface

// File: rtl/pulse_stretcher_counter.sv
// Loadable down-counter that saturates at zero; load has priority over enable.
// Optional retrigger behaviour is selected in pulse_stretcher.sv via STRETCH_RETRIGGER_EN.
module stretch_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Counter register: load, saturating decrement, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= value;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a len-cycle level, followed by a HOLDOFF rejection window.
// Define STRETCH_RETRIGGER_EN to let a trigger during a stretch restart it.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int LEN_W   = DEFAULT_LEN_W,
  parameter int HOLDOFF = DEFAULT_HOLDOFF
) (
  input  logic              clk,
  input  logic              rst_n,
  pulse_stretcher_if.slave  bus
);

  localparam int              HOLD_W    = count_w(HOLDOFF - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HOLD_W'(HOLDOFF - 1) : '0;

  stretch_state_t state_r;
  stretch_state_t state_s;
  logic           len_nz_s;
  logic           retrig_s;
  logic           stretch_load_s;
  logic           hold_load_s;
  logic           stretch_zero_s;
  logic           hold_zero_s;
  pulse_t         done_s;
  pulse_t         ovr_s;
  logic           dout_r;
  pulse_t         done_r;
  pulse_t         ovr_r;

  assign len_nz_s = (bus.len != '0);

`ifdef STRETCH_RETRIGGER_EN
  assign retrig_s = bus.trig & len_nz_s;
`else
  assign retrig_s = 1'b0;
`endif

  // Counters hold (remaining - 1) so the zero flag marks the last cycle of a phase
  stretch_counter #(.W(LEN_W)) u_stretch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (stretch_load_s),
    .en    (state_r == STRETCH),
    .value (bus.len - LEN_W'(1)),
    .zero  (stretch_zero_s)
  );

  stretch_counter #(.W(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (hold_load_s),
    .en    (state_r == HOLD),
    .value (HOLD_LOAD),
    .zero  (hold_zero_s)
  );

  // Next-state, counter control and pulse decode
  always_comb begin
    state_s        = state_r;
    stretch_load_s = 1'b0;
    hold_load_s    = 1'b0;
    done_s         = PULSE_OFF;
    ovr_s          = PULSE_OFF;
    case (state_r)
      IDLE: begin
        if (bus.trig && len_nz_s) begin
          stretch_load_s = 1'b1;
          state_s        = STRETCH;
        end else begin
          ovr_s   = bus.trig;
          state_s = IDLE;
        end
      end
      STRETCH: begin
        if (retrig_s) begin
          stretch_load_s = 1'b1;
          state_s        = STRETCH;
        end else begin
          ovr_s = bus.trig;
          if (stretch_zero_s) begin
            done_s = PULSE_ON;
            if (HOLDOFF > 0) begin
              hold_load_s = 1'b1;
              state_s     = HOLD;
            end else begin
              state_s = IDLE;
            end
          end else begin
            state_s = STRETCH;
          end
        end
      end
      HOLD: begin
        ovr_s = bus.trig;
        if (hold_zero_s) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      dout_r  <= 1'b0;
      done_r  <= PULSE_OFF;
      ovr_r   <= PULSE_OFF;
    end else begin
      state_r <= state_s;
      dout_r  <= (state_s == STRETCH);
      done_r  <= done_s;
      ovr_r   <= ovr_s;
    end
  end

  assign bus.dout = dout_r;
  assign bus.done = done_r;
  assign bus.ovr  = ovr_r;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed and random stimulus for pulse_stretcher against an edge-time reference model.
// Honours STRETCH_RETRIGGER_EN in the reference model when the macro is defined.
module tb_pulse_stretcher;
  import pulse_pkg::*;

  localparam int LEN_W   = 8;
  localparam int HOLDOFF = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pulse_stretcher_if #(.LEN_W(LEN_W)) bus ();

  pulse_stretcher #(.LEN_W(LEN_W), .HOLDOFF(HOLDOFF)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  // Reference model: edge index t, edge at which the stretch ends, last edge of hold-off
  int   t;
  int   end_e;
  int   free_e;
  logic exp_dout;
  logic exp_done;
  logic exp_ovr;
  int   high_cnt;
  int   done_cnt;
  int   ovr_cnt;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    end_e  = -1;
    free_e = -1;
  endtask

  task automatic model_edge(input logic tr, input int ln);
    exp_ovr = 1'b0;
    if (t > free_e) begin
      if (tr && ln != 0) begin
        end_e  = t + ln;
        free_e = end_e + HOLDOFF;
      end else begin
        exp_ovr = tr;
      end
    end else if (t <= end_e) begin
`ifdef STRETCH_RETRIGGER_EN
      if (tr && ln != 0) begin
        end_e  = t + ln;
        free_e = end_e + HOLDOFF;
      end else begin
        exp_ovr = tr;
      end
`else
      exp_ovr = tr;
`endif
    end else begin
      exp_ovr = tr;
    end
    exp_dout = (t < end_e);
    exp_done = (t == end_e);
    t++;
  endtask

  task automatic step(input logic tr, input int ln);
    @(negedge clk);
    bus.trig = tr;
    bus.len  = LEN_W'(ln);
    @(posedge clk);
    model_edge(tr, ln);
    #1;
    check("dout", bus.dout, exp_dout);
    check("done", bus.done, exp_done);
    check("ovr", bus.ovr, exp_ovr);
    high_cnt += int'(bus.dout);
    done_cnt += int'(bus.done);
    ovr_cnt  += int'(bus.ovr);
  endtask

  task automatic clear_counts();
    high_cnt = 0;
    done_cnt = 0;
    ovr_cnt  = 0;
  endtask

  initial begin
    bus.trig = 1'b0;
    bus.len  = '0;
    clear_counts();
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", bus.dout, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ovr", bus.ovr, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();

    // Basic stretch, len=5
    clear_counts();
    step(1'b1, 5);
    repeat (12) step(1'b0, 0);
    check_int("basic_high", high_cnt, 5);
    check_int("basic_done", done_cnt, 1);
    check_int("basic_ovr", ovr_cnt, 0);

    // Hold-off rejection then acceptance, len=3
    clear_counts();
    step(1'b1, 3);
    repeat (4) step(1'b0, 3);
    step(1'b1, 3);
    repeat (2) step(1'b0, 3);
    step(1'b1, 3);
    repeat (10) step(1'b0, 0);
    check_int("hold_high", high_cnt, 6);
    check_int("hold_ovr", ovr_cnt, 1);

    // Zero length
    clear_counts();
    step(1'b1, 0);
    repeat (3) step(1'b0, 0);
    check_int("zero_high", high_cnt, 0);
    check_int("zero_ovr", ovr_cnt, 1);

    // Max length
    clear_counts();
    step(1'b1, 255);
    repeat (262) step(1'b0, 0);
    check_int("max_high", high_cnt, 255);
    check_int("max_done", done_cnt, 1);

    // Trigger at stretch cycle 3
    clear_counts();
    step(1'b1, 8);
    repeat (2) step(1'b0, 8);
    step(1'b1, 8);
    repeat (16) step(1'b0, 8);
    check_int("retrig_done", done_cnt, 1);
`ifdef STRETCH_RETRIGGER_EN
    check_int("retrig_high", high_cnt, 11);
    check_int("retrig_ovr", ovr_cnt, 0);
`else
    check_int("retrig_high", high_cnt, 8);
    check_int("retrig_ovr", ovr_cnt, 1);
`endif

    // Rejected trigger on the final stretch edge: done and ovr together
    step(1'b1, 4);
    repeat (3) step(1'b0, 4);
    step(1'b1, 0);
    check("coinc_done", bus.done, 1'b1);
    check("coinc_ovr", bus.ovr, 1'b1);
    repeat (8) step(1'b0, 0);

    // Continuous trig: stretch, ovr during hold, restart
    clear_counts();
    repeat (20) step(1'b1, 3);
    repeat (10) step(1'b0, 0);

    // Asynchronous reset mid-stretch
    clear_counts();
    step(1'b1, 10);
    repeat (3) step(1'b0, 0);
    bus.trig = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_dout", bus.dout, 1'b0);
    check("async_done", bus.done, 1'b0);
    check("async_ovr", bus.ovr, 1'b0);
    repeat (12) begin
      @(posedge clk);
      #1;
      check("inrst_done", bus.done, 1'b0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    model_reset();
    clear_counts();
    step(1'b1, 3);
    repeat (9) step(1'b0, 0);
    check_int("postrst_high", high_cnt, 3);
    check_int("postrst_done", done_cnt, 1);

    // Random triggers and lengths
    repeat (800) begin
      logic tr;
      int   ln;
      tr = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       ln = 0;
        1:       ln = int'($urandom_range(13, 40));
        default: ln = int'($urandom_range(1, 12));
      endcase
      step(tr, ln);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Inverse of the single pulser. It takes a one-cycle pulse, typically a single-pulser output, and drives a clean level-high output for a programmable number of clock cycles. A programmable hold-off window follows each stretch. Used downstream of the button conditioning chain to drive LEDs, buzzers and timed enables that need a visible or long-lasting level.

Parameters:
LEN_W, 8, width of the run-time length input and the internal down-counter
HOLDOFF, 4, fixed cycles after each stretch during which triggers are rejected (0 = no hold-off)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
trig  input  1  trigger, sampled every rising edge, nominally a one-cycle pulse
len  input  LEN_W  stretch length in cycles, sampled only when a trigger is accepted
dout  output  1  stretched level output, registered
done  output  1  one-cycle pulse marking the end of a stretch, registered
ovr  output  1  one-cycle pulse when a trigger is rejected, registered

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: on rst_n low, immediately force state=IDLE, counter=0, dout=0, done=0, ovr=0. Reset mid-stretch aborts with no done pulse. Release is synchronous to the next clk edge.
- States:
  - IDLE: dout=0.
  - STRETCH: dout=1.
  - HOLD: dout=0, hold-off counting.
- IDLE, trig=1, len!=0 at edge N:
  - latch len into counter, go to STRETCH.
  - dout=1 from edge N through edge N+len-1, so exactly len cycles.
  - At edge N+len: dout=0 and done=1 for one cycle.
  - Then go to HOLD, or to IDLE if HOLDOFF=0.
- IDLE, trig=1, len==0: trigger ignored. No dout, no done, ovr=1 for one cycle.
- STRETCH: counter decrements each edge. Its value is unsigned, never wraps, and saturates at its terminal value.
- A trig during STRETCH (feature off) or during HOLD is rejected: ovr=1 for the cycle after the sampling edge. State and counter are unaffected.
- HOLD: lasts exactly HOLDOFF cycles, then IDLE. A trig on the edge that leaves HOLD is still rejected. The first acceptable trigger is on the following edge.
- trig held high continuously: one stretch, then ovr pulses during HOLD, then a new stretch once back in IDLE. Level-triggered by design.
- A len change after acceptance has no effect on the running stretch.
- Max stretch is 2^LEN_W-1 cycles. done and ovr can be high in the same cycle (rejected trigger on the final stretch edge).

Optional Feature:
Macro STRETCH_RETRIGGER_EN.
- Defined: trig with len!=0 during STRETCH reloads the counter with the current len. dout stays high with no gap; the new stretch ends len cycles after the retrigger edge. done fires only at the final end, and ovr is not asserted for a retrigger. A retrigger with len==0 is rejected with ovr.
- Undefined: triggers during STRETCH are rejected as described above.

Decomposition:
- Package pulse_pkg holds:
  - typedef enum logic [1:0] stretch_state_t {IDLE, STRETCH, HOLD}
  - localparam DEFAULT_LEN_W = 8
  - shared done/ovr pulse-type conventions
- One sub-module, stretch_counter: a loadable, saturating down-counter (load, en, value, zero flag), instantiated twice, once for the stretch length and once for the hold-off.
- FSM and output registers live in pulse_stretcher.

Test Plan:
1. Reset: assert rst_n=0 mid-stretch (len=10, at cycle 4) -> dout, done, ovr go to 0 immediately, no done pulse; after release, trig is accepted normally.
2. Basic stretch: LEN_W=8, HOLDOFF=4, len=5, single trig pulse -> dout high exactly 5 cycles starting the edge after trig, done=1 on the 6th cycle, ovr stays 0.
3. Hold-off rejection: len=3, second trig 2 cycles after dout falls -> ovr=1 for one cycle, no stretch; trig 5 cycles after fall -> accepted, 3-cycle stretch.
4. Zero length and max length: len=0 -> ovr=1, dout stays 0; len=255 -> dout high 255 cycles, single done.
5. Retrigger, feature off: len=8, trig again at stretch cycle 3 -> ovr=1, dout still falls after 8 cycles total.
6. Retrigger, STRETCH_RETRIGGER_EN defined: same stimulus with len=8 -> dout continuous for 11 cycles, one done, ovr=0.
